// File: rtl/rtype_sequencer.sv
// rtype_sequencer: LEGv8 R-format sequencer (IDLE/DECODE/EXECUTE/WRITEBACK), all outputs registered.
// Define SEQ_XZR_EN to suppress the register write for Rd=31 (XZR); done still pulses.
module rtype_sequencer #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_ADDR_W = 6
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [31:0]           instr,
   output logic [REG_ADDR_W-1:0] Read1,
   output logic [REG_ADDR_W-1:0] Read2,
   output logic [REG_ADDR_W-1:0] WriteReg,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  RegWrite,
   output logic [1:0]            ALUOp,
   output logic [10:0]           Opcode_field,
   input  logic [DATA_WIDTH-1:0] ALU_result,
   input  logic                  Zero,
   output logic                  result_zero,
   output logic                  done,
   output logic                  illegal
);
   typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
   state_t state, state_next;
   logic [4:0] rd;
   logic accept, supported, write_en, ready_d, illegal_d, done_d, write_d, unused_shamt;
   assign unused_shamt = ^instr[15:10];
   assign accept = instr_ready & instr_valid;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         instr_ready  <= 1'b1;
         illegal      <= 1'b0;
         done         <= 1'b0;
         RegWrite     <= 1'b0;
         Read1        <= '0;
         Read2        <= '0;
         WriteReg     <= '0;
         WriteData    <= '0;
         result_zero  <= 1'b0;
         ALUOp        <= 2'b00;
         Opcode_field <= '0;
         rd           <= '0;
      end else begin
         state       <= state_next;
         instr_ready <= ready_d;
         illegal     <= illegal_d;
         done        <= done_d;
         RegWrite    <= write_d;
         if (accept) begin
            Read1        <= REG_ADDR_W'(instr[9:5]);
            Read2        <= REG_ADDR_W'(instr[20:16]);
            Opcode_field <= instr[31:21];
            ALUOp        <= 2'b10;
            rd           <= instr[4:0];
         end
         if (state == EXECUTE) begin
            WriteData   <= ALU_result;
            result_zero <= Zero;
            WriteReg    <= REG_ADDR_W'(rd);
         end
      end
   end
   // illegal is already valid during DECODE, so it doubles as the decode verdict
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = accept ? DECODE : IDLE;
         DECODE:  state_next = illegal ? IDLE : EXECUTE;
         EXECUTE: state_next = WRITEBACK;
         default: state_next = IDLE;
      endcase
   end
   always_comb begin
      supported = instr[31:21] inside {11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000};
      write_en  = 1'b1;
`ifdef SEQ_XZR_EN
      write_en  = rd != 5'd31;
`endif
      ready_d   = state_next == IDLE;
      illegal_d = accept & ~supported;
      done_d    = state == EXECUTE;
      write_d   = (state == EXECUTE) & write_en;
   end
endmodule

// File: tb/tb_rtype_sequencer.sv
// tb_rtype_sequencer: directed + randomized bench with a register-file/ALU environment and a reference model.
module tb_rtype_sequencer;
   localparam logic [10:0] OP_AND = 11'b10001010000;
   localparam logic [10:0] OP_ORR = 11'b10101010000;
   localparam logic [10:0] OP_ADD = 11'b10001011000;
   localparam logic [10:0] OP_SUB = 11'b11001011000;
   localparam logic [10:0] OP_BAD = 11'b11111000010;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready, RegWrite, Zero, result_zero, done, illegal;
   logic [5:0]  Read1, Read2, WriteReg;
   logic [63:0] WriteData, ALU_result;
   logic [1:0]  ALUOp;
   logic [10:0] Opcode_field;
   logic [63:0] regs [64];
   logic [63:0] last_wd;
   logic        last_z;
   int checks = 0;
   int failures = 0;

   rtype_sequencer #(.DATA_WIDTH(64), .REG_ADDR_W(6)) dut (
      .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .WriteData(WriteData),
      .RegWrite(RegWrite), .ALUOp(ALUOp), .Opcode_field(Opcode_field), .ALU_result(ALU_result),
      .Zero(Zero), .result_zero(result_zero), .done(done), .illegal(illegal)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] alu(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         OP_AND:  return a & b;
         OP_ORR:  return a | b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         default: return '0;
      endcase
   endfunction

   assign ALU_result = alu(Opcode_field, regs[Read1], regs[Read2]);
   assign Zero = ALU_result == 64'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ready"}, instr_ready, 1);
      chk({tag, "_regwrite"}, RegWrite, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_illegal"}, illegal, 0);
      chk({tag, "_read1"}, Read1, 0);
      chk({tag, "_read2"}, Read2, 0);
      chk({tag, "_writereg"}, WriteReg, 0);
      chk({tag, "_writedata"}, WriteData, 0);
      chk({tag, "_aluop"}, ALUOp, 0);
      chk({tag, "_opcode"}, Opcode_field, 0);
      chk({tag, "_rzero"}, result_zero, 0);
   endtask

   // One instruction, checked cycle by cycle; busy-time instr_valid noise must be ignored.
   task automatic run(input logic [10:0] op, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
      logic ok, rw;
      logic [63:0] exp;
      ok = op inside {OP_AND, OP_ORR, OP_ADD, OP_SUB};
      exp = alu(op, regs[rn], regs[rm]);
`ifdef SEQ_XZR_EN
      rw = rd != 5'd31;
`else
      rw = 1'b1;
`endif
      @(negedge clock);
      chk("ready_idle", instr_ready, 1);
      instr = {op, rm, 6'($urandom), rn, rd};
      instr_valid = 1'b1;
      @(negedge clock);
      chk("dec_read1", Read1, rn);
      chk("dec_read2", Read2, rm);
      chk("dec_opcode", Opcode_field, op);
      chk("dec_aluop", ALUOp, 2'b10);
      chk("dec_illegal", illegal, !ok);
      chk("dec_regwrite", RegWrite, 0);
      chk("dec_done", done, 0);
      chk("dec_ready", instr_ready, 0);
      instr = $urandom;
      instr_valid = 1'($urandom);
      @(negedge clock);
      if (!ok) begin
         chk("ill_clear", illegal, 0);
         chk("ill_ready", instr_ready, 1);
         chk("ill_regwrite", RegWrite, 0);
         chk("ill_done", done, 0);
         chk("ill_wd_hold", WriteData, last_wd);
         instr_valid = 1'b0;
      end else begin
         chk("exe_read1", Read1, rn);
         chk("exe_read2", Read2, rm);
         chk("exe_opcode", Opcode_field, op);
         chk("exe_aluop", ALUOp, 2'b10);
         chk("exe_regwrite", RegWrite, 0);
         chk("exe_done", done, 0);
         chk("exe_ready", instr_ready, 0);
         instr = $urandom;
         @(negedge clock);
         chk("wb_regwrite", RegWrite, rw);
         chk("wb_done", done, 1);
         chk("wb_writereg", WriteReg, rd);
         chk("wb_writedata", WriteData, exp);
         chk("wb_rzero", result_zero, exp == 64'd0);
         chk("wb_ready", instr_ready, 0);
         instr_valid = 1'b0;
         last_wd = exp;
         last_z = exp == 64'd0;
         @(negedge clock);
         chk("post_done", done, 0);
         chk("post_regwrite", RegWrite, 0);
         chk("post_ready", instr_ready, 1);
         chk("post_wd_hold", WriteData, last_wd);
         chk("post_rz_hold", result_zero, last_z);
      end
   endtask

   initial begin
      logic [10:0] ops [4];
      logic [10:0] op;
      ops[0] = OP_AND; ops[1] = OP_ORR; ops[2] = OP_ADD; ops[3] = OP_SUB;
      for (int i = 0; i < 64; i++) regs[i] = {$urandom, $urandom};
      regs[5] = 64'h5555555555555555;
      regs[10] = 64'hAAAAAAAAAAAAAAAA;
      last_wd = '0;
      last_z = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_reset("por");
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      run(OP_AND, 5'd1, 5'd5, 5'd10);
      chk("and_value", last_wd, 64'h0);
      run(OP_ORR, 5'd2, 5'd5, 5'd10);
      run(OP_ADD, 5'd3, 5'd5, 5'd10);
      chk("add_value", WriteData, 64'hFFFFFFFFFFFFFFFF);
      run(OP_SUB, 5'd4, 5'd5, 5'd10);
      chk("sub_value", WriteData, 64'hAAAAAAAAAAAAAAAB);
      run(OP_BAD, 5'd6, 5'd5, 5'd10);

      // abort an ADD mid-EXECUTE with an asynchronous reset
      @(negedge clock);
      instr = {OP_ADD, 5'd10, 6'd0, 5'd5, 5'd7};
      instr_valid = 1'b1;
      @(negedge clock);
      instr_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1 check_reset("midrst");
      repeat (3) begin
         @(negedge clock);
         chk("rst_regwrite", RegWrite, 0);
         chk("rst_done", done, 0);
      end
      reset_n = 1'b1;
      last_wd = '0;
      last_z = 1'b0;
      run(OP_ADD, 5'd8, 5'd5, 5'd10);
      run(OP_ADD, 5'd31, 5'd5, 5'd10);

      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 4) == 4) ? 11'($urandom) : ops[$urandom_range(0, 3)];
         run(op, 5'($urandom), 5'($urandom), 5'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
